// File: rtl/reg_xfer_ctl.sv
// Bus-side transfer sequencer for the 8-bit counter/register bank: turns MOVE/INC/READ/MOVEINC
// commands into per-register oe_n / we_n / cnt strobes and captures the bus at the load edge.
module reg_xfer_ctl #(
    parameter int NREG = 4,
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [1:0]      op,
    input  logic [IDXW-1:0] src,
    input  logic [IDXW-1:0] dst,
    input  logic [7:0]      bus,
    output logic [NREG-1:0] oe_n,
    output logic [NREG-1:0] we_n,
    output logic [NREG-1:0] cnt,
    output logic [7:0]      cap,
    output logic            busy,
    output logic            ack,
    output logic            err
);

    localparam logic [1:0] OP_MOVE    = 2'b00;
    localparam logic [1:0] OP_INC     = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_MOVEINC = 2'b11;

    localparam logic [IDXW:0] NREG_W = (IDXW+1)'(NREG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_LOAD,
        S_INC,
        S_ACK
    } state_t;

    state_t          state_reg;
    logic [1:0]      op_reg;
    logic [IDXW-1:0] src_reg;
    logic [IDXW-1:0] dst_reg;
    logic            bad_cmd;

    function automatic logic [NREG-1:0] sel(input logic [IDXW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (idx == IDXW'(i));
        end
        return v;
    endfunction

    // INC has no source and READ has no destination, so those fields are don't-care.
    assign bad_cmd = ((op != OP_INC)  && ({1'b0, src} >= NREG_W)) ||
                     ((op != OP_READ) && ({1'b0, dst} >= NREG_W));

    // Outputs are registered alongside the state they belong to, so each strobe
    // appears exactly for the cycle the FSM spends in the matching state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_MOVE;
            src_reg   <= '0;
            dst_reg   <= '0;
            oe_n      <= '1;
            we_n      <= '1;
            cnt       <= '0;
            cap       <= 8'h00;
            busy      <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            oe_n <= '1;
            we_n <= '1;
            cnt  <= '0;
            busy <= 1'b0;
            ack  <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        op_reg  <= op;
                        src_reg <= src;
                        dst_reg <= dst;
                        if (bad_cmd) begin
                            state_reg <= S_ACK;
                            ack       <= 1'b1;
                            err       <= 1'b1;
                        end else if (op == OP_INC) begin
                            state_reg <= S_INC;
                            cnt       <= sel(dst);
                            busy      <= 1'b1;
                        end else begin
                            state_reg <= S_DRIVE;
                            oe_n      <= ~sel(src);
                            busy      <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    state_reg <= S_LOAD;
                    oe_n      <= ~sel(src_reg);
                    if (op_reg == OP_MOVE || op_reg == OP_MOVEINC) begin
                        we_n <= ~sel(dst_reg);
                    end
                    busy <= 1'b1;
                end
                S_LOAD: begin
                    cap <= bus;
                    if (op_reg == OP_MOVEINC) begin
                        // Post-increment targets the source, after its value was copied out.
                        state_reg <= S_INC;
                        cnt       <= sel(src_reg);
                        busy      <= 1'b1;
                    end else begin
                        state_reg <= S_ACK;
                        ack       <= 1'b1;
                    end
                end
                S_INC: begin
                    state_reg <= S_ACK;
                    ack       <= 1'b1;
                end
                S_ACK: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_xfer_ctl.sv
// Randomized bench for reg_xfer_ctl: drives a 4-register and a 3-register instance, emulates
// the register bank on the bus and checks strobes, cap and register contents against a model.
module tb_reg_xfer_ctl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       req_a [2];
    logic [1:0] op_a  [2];
    logic [1:0] src_a [2];
    logic [1:0] dst_a [2];
    logic [7:0] bus_a [2];
    logic [3:0] oe_a  [2];
    logic [3:0] we_a  [2];
    logic [3:0] cnt_a [2];
    logic [7:0] cap_a [2];
    logic       busy_a[2];
    logic       ack_a [2];
    logic       err_a [2];

    logic [3:0] oe4, we4, cnt4;
    logic [2:0] oe3, we3, cnt3;
    logic [7:0] cap4, cap3;
    logic       busy4, ack4, err4, busy3, ack3, err3;

    reg_xfer_ctl #(.NREG(4), .IDXW(2)) dut4 (
        .clk(clk), .rst(rst), .req(req_a[0]), .op(op_a[0]), .src(src_a[0]), .dst(dst_a[0]),
        .bus(bus_a[0]), .oe_n(oe4), .we_n(we4), .cnt(cnt4), .cap(cap4),
        .busy(busy4), .ack(ack4), .err(err4)
    );

    reg_xfer_ctl #(.NREG(3), .IDXW(2)) dut3 (
        .clk(clk), .rst(rst), .req(req_a[1]), .op(op_a[1]), .src(src_a[1]), .dst(dst_a[1]),
        .bus(bus_a[1]), .oe_n(oe3), .we_n(we3), .cnt(cnt3), .cap(cap3),
        .busy(busy3), .ack(ack3), .err(err3)
    );

    assign oe_a[0]  = oe4;
    assign we_a[0]  = we4;
    assign cnt_a[0] = cnt4;
    assign cap_a[0] = cap4;
    assign busy_a[0] = busy4;
    assign ack_a[0]  = ack4;
    assign err_a[0]  = err4;
    assign oe_a[1]  = {1'b1, oe3};
    assign we_a[1]  = {1'b1, we3};
    assign cnt_a[1] = {1'b0, cnt3};
    assign cap_a[1] = cap3;
    assign busy_a[1] = busy3;
    assign ack_a[1]  = ack3;
    assign err_a[1]  = err3;

    // Register bank emulation: the enabled register drives the bus, otherwise random junk.
    logic [7:0] bank [2][4];
    logic [7:0] junk [2];
    logic       poke_en = 1'b0;
    int         poke_k, poke_i;
    logic [7:0] poke_v;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            junk[k] <= 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (poke_en && poke_k == k && poke_i == i) bank[k][i] <= poke_v;
                else if (!we_a[k][i])                   bank[k][i] <= bus_a[k];
                else if (cnt_a[k][i])                   bank[k][i] <= bank[k][i] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus_a[k] = junk[k];
            for (int i = 0; i < 4; i++) begin
                if (!oe_a[k][i]) bus_a[k] = bank[k][i];
            end
        end
    end

    // Reference model state
    logic [7:0] m     [2][4];
    logic [7:0] m_cap [2];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nreg(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic set_reg(input int k, input int i, input logic [7:0] v);
        poke_k  = k;
        poke_i  = i;
        poke_v  = v;
        poke_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
        m[k][i] = v;
    endtask

    task automatic idle_check(input int k, input string tag);
        check($sformatf("%s k%0d oe_n", tag, k), 8'(oe_a[k]), 8'h0f);
        check($sformatf("%s k%0d we_n", tag, k), 8'(we_a[k]), 8'h0f);
        check($sformatf("%s k%0d cnt", tag, k), 8'(cnt_a[k]), 8'h00);
        check($sformatf("%s k%0d busy", tag, k), 8'(busy_a[k]), 8'h00);
        check($sformatf("%s k%0d ack", tag, k), 8'(ack_a[k]), 8'h00);
    endtask

    // Issue one command at a negedge in IDLE; checks every cycle up to the IDLE cycle after ack.
    task automatic run_cmd(input int k, input int op, input int s, input int d, input bit hold);
        logic [3:0] t_oe [4];
        logic [3:0] t_we [4];
        logic [3:0] t_cnt[4];
        logic [7:0] v;
        int  len;
        int  n;
        bit  bad;
        n   = nreg(k);
        bad = (op != 1 && s >= n) || (op != 2 && d >= n);
        for (int c = 0; c < 4; c++) begin
            t_oe[c] = 4'hf; t_we[c] = 4'hf; t_cnt[c] = 4'h0;
        end
        if (bad) begin
            len = 1;
        end else begin
            case (op)
                0: begin
                    len = 3;
                    t_oe[0] = ~4'(1 << s); t_oe[1] = ~4'(1 << s); t_we[1] = ~4'(1 << d);
                end
                1: begin
                    len = 2;
                    t_cnt[0] = 4'(1 << d);
                end
                2: begin
                    len = 3;
                    t_oe[0] = ~4'(1 << s); t_oe[1] = ~4'(1 << s);
                end
                default: begin
                    len = 4;
                    t_oe[0] = ~4'(1 << s); t_oe[1] = ~4'(1 << s); t_we[1] = ~4'(1 << d);
                    t_cnt[2] = 4'(1 << s);
                end
            endcase
        end

        req_a[k] = 1'b1;
        op_a[k]  = 2'(op);
        src_a[k] = 2'(s);
        dst_a[k] = 2'(d);
        @(posedge clk);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check($sformatf("k%0d op%0d c%0d oe_n", k, op, c + 1), 8'(oe_a[k]), 8'(t_oe[c]));
            check($sformatf("k%0d op%0d c%0d we_n", k, op, c + 1), 8'(we_a[k]), 8'(t_we[c]));
            check($sformatf("k%0d op%0d c%0d cnt", k, op, c + 1), 8'(cnt_a[k]), 8'(t_cnt[c]));
            check($sformatf("k%0d op%0d c%0d busy", k, op, c + 1), 8'(busy_a[k]), 8'(c < len - 1));
            check($sformatf("k%0d op%0d c%0d ack", k, op, c + 1), 8'(ack_a[k]), 8'(c == len - 1));
            if (c == len - 1) check($sformatf("k%0d op%0d err", k, op), 8'(err_a[k]), 8'(bad));
            if (hold) begin
                op_a[k]  = 2'($urandom);
                src_a[k] = 2'($urandom);
                dst_a[k] = 2'($urandom);
            end else begin
                req_a[k] = 1'b0;
            end
        end

        if (!bad) begin
            case (op)
                0: begin m[k][d] = m[k][s]; m_cap[k] = m[k][s]; end
                1: m[k][d] = m[k][d] + 8'd1;
                2: m_cap[k] = m[k][s];
                default: begin
                    v = m[k][s];
                    m[k][d] = v;
                    m[k][s] = m[k][s] + 8'd1;
                    m_cap[k] = v;
                end
            endcase
        end
        check($sformatf("k%0d op%0d cap", k, op), cap_a[k], m_cap[k]);
        for (int i = 0; i < n; i++) begin
            check($sformatf("k%0d op%0d reg%0d", k, op, i), bank[k][i], m[k][i]);
        end

        @(negedge clk);
        idle_check(k, "post-ack idle");
        req_a[k] = 1'b0;
        $display("cmd k=%0d op=%0d src=%0d dst=%0d hold=%0d err=%0d cap=%02h",
                 k, op, s, d, hold, bad, m_cap[k]);
    endtask

    task automatic reset_mid_move();
        set_reg(0, 1, 8'h3C);
        req_a[0] = 1'b1; op_a[0] = 2'd0; src_a[0] = 2'd1; dst_a[0] = 2'd2;
        @(posedge clk);
        @(negedge clk);
        req_a[0] = 1'b0;
        check("rstmid c1 oe_n", 8'(oe_a[0]), 8'h0d);
        @(negedge clk);
        check("rstmid c2 we_n", 8'(we_a[0]), 8'h0b);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m[0][2] = m[0][1];
        m_cap[0] = 8'h00;
        m_cap[1] = 8'h00;
        idle_check(0, "rstmid after");
        check("rstmid cap", cap_a[0], 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid tail%0d ack", c), 8'(ack_a[0]), 8'h00);
            check($sformatf("rstmid tail%0d oe_n", c), 8'(oe_a[0]), 8'h0f);
        end
        check("rstmid reg2", bank[0][2], m[0][2]);
        $display("cmd reset during LOAD of MOVE src=1 dst=2");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b0; op_a[k] = 2'd0; src_a[k] = 2'd0; dst_a[k] = 2'd0;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            idle_check(k, "reset");
            check($sformatf("reset k%0d cap", k), cap_a[k], 8'h00);
            check($sformatf("reset k%0d err", k), 8'(err_a[k]), 8'h00);
            m_cap[k] = 8'h00;
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < nreg(k); i++) set_reg(k, i, 8'($urandom));

        set_reg(0, 1, 8'h5A);
        run_cmd(0, 0, 1, 2, 0);
        set_reg(0, 3, 8'hFF);
        run_cmd(0, 1, 0, 3, 0);
        set_reg(0, 3, 8'h0F);
        run_cmd(0, 1, 0, 3, 0);
        set_reg(0, 0, 8'h20);
        run_cmd(0, 3, 0, 1, 0);
        run_cmd(0, 0, 2, 2, 0);
        run_cmd(0, 3, 1, 1, 0);
        run_cmd(0, 2, 3, 0, 0);
        run_cmd(1, 2, 3, 0, 0);
        run_cmd(1, 1, 0, 3, 0);
        run_cmd(1, 3, 0, 3, 0);
        run_cmd(1, 0, 2, 0, 0);
        run_cmd(0, 0, 1, 3, 1);
        run_cmd(0, 3, 2, 0, 1);
        run_cmd(0, 1, 0, 2, 0);
        reset_mid_move();

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_reg(0, $urandom_range(0, 3), 8'hFF);
            end
            run_cmd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_xfer_ctl.md
Name: reg_xfer_ctl

Overview:
- Bus-side initiator for the 8-bit counter/register blocks on the shared data bus.
- Accepts transfer commands over a req/ack handshake.
- Sequences the per-register active-low output-enable, active-low load and count strobes to move, read, increment or move-with-post-increment register contents.
- Captures the bus value seen at each load/read edge. Sits between the instruction decoder and the register bank.

Parameters:
- NREG, 4, number of registers attached to the bus (2..8).
- IDXW, 2, register index width; must satisfy 2**IDXW >= NREG.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  1  command valid; sampled only in IDLE.
- op  input  2  00 MOVE, 01 INC, 10 READ, 11 MOVEINC.
- src  input  IDXW  source register index (MOVE, READ, MOVEINC).
- dst  input  IDXW  destination register index (MOVE, INC, MOVEINC).
- bus  input  8  shared data bus, driven by whichever register has oe_n low.
- oe_n  output  NREG  per-register output enable, active low.
- we_n  output  NREG  per-register load, active low.
- cnt  output  NREG  per-register count enable, active high.
- cap  output  8  last captured bus value.
- busy  output  1  high from the accept edge until the cycle before ack.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack; 1 = command rejected.

Behaviour:
- Reset (rst low at an edge), taking effect on that edge from any state:
  - state=IDLE; oe_n, we_n all 1; cnt all 0.
  - cap=8'h00; busy=0, ack=0, err=0.
  - An in-flight command is abandoned; no strobe is asserted on the following cycle.
- All outputs are registered. Strobes are decoded from the registered state and the latched src/dst, so they are glitch-free.
- At most one oe_n bit is low in any cycle. At most one we_n bit is low, and at most one cnt bit is high.
- Accept: IDLE with req=1 at an edge.
  - op, src and dst are latched; later input changes are ignored until return to IDLE.
  - req while not IDLE is ignored; the requester re-asserts after ack.
- Range check at accept: if src>=NREG (MOVE/READ/MOVEINC) or dst>=NREG (MOVE/INC/MOVEINC):
  - Next state is ACK with err=1; no strobes; cap unchanged.
- States: IDLE, DRIVE, LOAD, INC, ACK.
- Cycles are numbered from the accept edge (cycle 1 = first cycle after accept). The strobes listed for each state are the outputs during that state.
  - MOVE: DRIVE (oe_n[src]=0) -> LOAD (oe_n[src]=0, we_n[dst]=0; cap<=bus at exit edge) -> ACK. ack in cycle 3.
  - READ: DRIVE (oe_n[src]=0) -> LOAD (oe_n[src]=0, no we; cap<=bus at exit edge) -> ACK. ack in cycle 3.
  - INC: INC (cnt[dst]=1) -> ACK. ack in cycle 2.
  - MOVEINC: DRIVE -> LOAD as MOVE -> INC (cnt[src]=1) -> ACK. ack in cycle 4.
  - ACK: ack=1, busy=0, err per range check (0 for valid commands); next state IDLE.
  - A new command is accepted at the earliest on the edge ending the first IDLE cycle after ACK.
- busy=1 in DRIVE, LOAD and INC.
- Boundary cases:
  - src==dst MOVE is legal: the register reloads its own value, cap=that value.
  - src==dst MOVEINC leaves the register incremented by 1.
  - INC of a register holding 8'hFF wraps to 8'h00 (register-side carry); the controller does nothing extra.
  - bus is sampled only at the LOAD exit edge; bus contents in other cycles never affect cap.

Test Plan:
- Reset with rst=0 mid-MOVE, during LOAD -> next cycle all oe_n/we_n =1, cnt=0, cap=00, busy=0; no ack follows.
- MOVE src=1 dst=2, reg1=8'h5A -> cycle1 oe_n=4'b1101; cycle2 oe_n=4'b1101, we_n=4'b1011; cycle3 ack=1 err=0, cap=5A; reg2 reads 5A afterwards.
- INC dst=3, reg3=8'hFF -> cycle1 cnt=4'b1000; cycle2 ack=1; reg3=00. Repeat with reg3=8'h0F -> reg3=10 (carry across nibble).
- MOVEINC src=0 dst=1, reg0=8'h20 -> cycles1-2 as MOVE; cycle3 cnt=4'b0001; cycle4 ack=1; reg1=20, reg0=21, cap=20.
- Error: NREG=3, READ src=3 -> cycle1 ack=1 err=1; no strobe ever asserted; cap unchanged.
- req held high with op/src changing during busy -> only the first command executes. Next accept occurs one cycle after ack (IDLE cycle), and strobes are never overlapping across the two commands.
